// File: rtl/sound_scheduler.sv
// Sound request scheduler: arbitrates per-source request pulses into a small FIFO and
// drives the audio player start/done/abort handshake. Optional macro SOUND_SCHED_DEDUP_EN
// discards non-priority requests that repeat the FIFO tail id or the id playing now.
module sound_scheduler #(
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned TIMEOUT_FRAMES = 90,
  parameter logic [15:0] PRIO_MASK      = 16'h0006
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic [NUM_SRC-1:0]             req_valid,
  input  logic [4*NUM_SRC-1:0]           req_id,
  input  logic                           snd_done,
  output logic                           snd_start,
  output logic [3:0]                     snd_id,
  output logic                           snd_abort,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic [7:0]                     drop_cnt
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_FRAMES + 1);
  localparam int unsigned NS_W  = $clog2(NUM_SRC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAYING = 2'd1, ABORT = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [3:0]       fifo_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d, waddr;
  logic [CNT_W-1:0] count_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [7:0]       drop_q, drop_d;
  logic [8:0]       drop_sum;
  logic             snd_start_q, start_d, snd_abort_q, abort_d, busy_q, busy_d;
  logic [3:0]       snd_id_q, id_d;
  logic             acc_valid, acc_prio, dup, pop, we, ovf, wd_fire;
  logic [3:0]       acc_id;
  logic [NS_W-1:0]  nz_cnt, others;

  // Pick one request per cycle: first priority id wins, else lowest index.
  always_comb begin
    acc_valid = 1'b0;
    acc_prio  = 1'b0;
    acc_id    = 4'd0;
    nz_cnt    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_valid[i] && (req_id[4*i +: 4] != 4'd0)) begin
        nz_cnt = nz_cnt + NS_W'(1);
        if (PRIO_MASK[req_id[4*i +: 4]] && !acc_prio) begin
          acc_valid = 1'b1;
          acc_prio  = 1'b1;
          acc_id    = req_id[4*i +: 4];
        end else if (!acc_valid) begin
          acc_valid = 1'b1;
          acc_id    = req_id[4*i +: 4];
        end
      end
    end
    others = nz_cnt - NS_W'(acc_valid);
  end

`ifdef SOUND_SCHED_DEDUP_EN
  assign dup = ((count_q != '0) && (acc_id == fifo_q[wr_q - PTR_W'(1)])) ||
               ((state_q == PLAYING) && (acc_id == snd_id_q));
`else
  assign dup = 1'b0;
`endif

  // Hold off issuing while an abort pulse is on the wire so the player sees a gap.
  assign pop     = (state_q == IDLE) && (count_q != '0) && !snd_abort_q;
  assign wd_fire = (state_q == PLAYING) && startOfFrame &&
                   (wd_q == WD_W'(TIMEOUT_FRAMES - 1));

  // FIFO pointer/count update; a priority accept replaces the whole queue.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = count_q;
    waddr = wr_q;
    we    = 1'b0;
    ovf   = 1'b0;
    if (pop) begin
      rd_d  = rd_q + PTR_W'(1);
      cnt_d = count_q - CNT_W'(1);
    end
    if (acc_valid && acc_prio) begin
      rd_d  = '0;
      wr_d  = PTR_W'(1);
      cnt_d = CNT_W'(1);
      waddr = '0;
      we    = 1'b1;
    end else if (acc_valid && !dup) begin
      if (cnt_d == CNT_W'(QUEUE_DEPTH)) begin
        ovf = 1'b1;
      end else begin
        wr_d  = wr_q + PTR_W'(1);
        cnt_d = cnt_d + CNT_W'(1);
        we    = 1'b1;
      end
    end
  end

  always_comb begin
    wd_d = '0;
    if (state_q == PLAYING) wd_d = startOfFrame ? wd_q + WD_W'(1) : wd_q;
    drop_sum = {1'b0, drop_q} + 9'(others) + 9'(ovf);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: done beats priority preemption, which beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = PLAYING;
      PLAYING: begin
        if (snd_done)                   state_d = IDLE;
        else if (acc_valid && acc_prio) state_d = ABORT;
        else if (wd_fire)               state_d = IDLE;
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d = pop;
    id_d    = pop ? fifo_q[rd_q] : snd_id_q;
    abort_d = (state_q == ABORT) ||
              ((state_q == PLAYING) && !snd_done && !(acc_valid && acc_prio) && wd_fire);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fifo_q      <= '{default: '0};
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      wd_q        <= '0;
      drop_q      <= '0;
      snd_start_q <= 1'b0;
      snd_id_q    <= 4'd0;
      snd_abort_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (we) fifo_q[waddr] <= acc_id;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= cnt_d;
      wd_q        <= wd_d;
      drop_q      <= drop_d;
      snd_start_q <= start_d;
      snd_id_q    <= id_d;
      snd_abort_q <= abort_d;
      busy_q      <= busy_d;
    end
  end

  assign snd_start   = snd_start_q;
  assign snd_id      = snd_id_q;
  assign snd_abort   = snd_abort_q;
  assign busy        = busy_q;
  assign queue_count = count_q;
  assign drop_cnt    = drop_q;

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Arbitrates sound requests from several game-logic sources (level FSM, menu, timer warning) onto the single audio player. One-cycle request pulses are queued in a small FIFO and issued one at a time with a start/done handshake. Win/loss-class sounds preempt everything else. A frame-based watchdog recovers from a player that never reports completion.

## Interface
Parameters:
- NUM_SRC, 3: number of requesters; source 0 = level FSM.
- QUEUE_DEPTH, 4: pending-request FIFO depth; power of 2, at least 2.
- TIMEOUT_FRAMES, 90: startOfFrame pulses allowed in PLAYING before forced abort (3 s at 30 Hz).
- PRIO_MASK, 16'h0006: bit k set means sound id k is priority (ids 1 Win, 2 Loss).

Ports (reset resetN, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- req_valid  in  NUM_SRC  per-source one-cycle request pulse
- req_id  in  4*NUM_SRC  source i id in bits [4i+3:4i]
- snd_done  in  1  player pulse: current sound finished
- snd_start  out  1  one-cycle pulse: begin playing snd_id
- snd_id  out  4  id of current/last issued sound
- snd_abort  out  1  one-cycle pulse: stop current sound now
- busy  out  1  high while not IDLE
- queue_count  out  $clog2(QUEUE_DEPTH)+1  pending entries
- drop_cnt  out  8  saturating count of discarded requests

## Operation
- Reset: every output is 0, the FIFO is empty, and the state is IDLE.
- Requests with id 0 are ignored and are not counted as drops.
- At most one request is accepted per cycle. Selection order:
  - the lowest-index valid source carrying a priority id;
  - otherwise the lowest-index valid source.
- Each other valid nonzero request in that cycle increments drop_cnt once.
- Non-priority accept: pushed to the FIFO tail. If the FIFO is full (after any same-cycle pop), the request is dropped and drop_cnt increments.
- Priority accept:
  - the FIFO is flushed and the priority id becomes the only entry (queue_count=1);
  - flushed entries are not counted as drops;
  - if the state is PLAYING, it moves to ABORT.
- States:
  - IDLE: if queue_count>0, pop the head, register snd_id, pulse snd_start, go to PLAYING.
  - PLAYING:
    - snd_done goes to IDLE;
    - otherwise a priority accept goes to ABORT;
    - otherwise the watchdog reaching TIMEOUT_FRAMES pulses snd_abort and goes to IDLE.
    - The watchdog clears on entry and counts startOfFrame pulses.
  - ABORT: pulse snd_abort for one cycle, then go to IDLE. The priority entry issues next.
- Simultaneous events:
  - snd_done together with a priority accept in PLAYING: done wins, no abort pulse, and the priority sound issues from IDLE.
  - snd_done outside PLAYING is ignored.
- drop_cnt saturates at 255.

## Timing
- snd_start, snd_id, snd_abort and busy are registered.
- Request pulse in cycle N with IDLE and an empty FIFO:
  - queue_count=1 in N+1;
  - snd_start high in N+2;
  - queue_count=0 in N+2;
  - busy high from N+2.
- Priority request in cycle N while PLAYING:
  - snd_abort high in N+2;
  - snd_start with the priority id in N+4.
- Watchdog: snd_abort is high the cycle after the TIMEOUT_FRAMES-th startOfFrame pulse.
- Back-to-back: after snd_done in cycle M with the FIFO non-empty, the next snd_start is high in M+2.
- Reset mid-operation clears everything immediately. No abort pulse is generated.

## Configuration
- SOUND_SCHED_DEDUP_EN defined: a non-priority request is discarded when its id equals either of:
  - the FIFO tail id;
  - snd_id while PLAYING.
  - It is not counted in drop_cnt.
- Not defined: every non-priority request is queued subject only to capacity.

## Test plan
- Single request: source 0 id 3 pulses at cycle 10 -> snd_start=1 and snd_id=3 at cycle 12; busy stays 1 until snd_done, then 0.
- Overflow: 6 id-4 requests in consecutive cycles while PLAYING, QUEUE_DEPTH=4 -> queue_count=4 and drop_cnt=2 (without DEDUP_EN); with DEDUP_EN -> queue_count=1 and drop_cnt=0.
- Preemption: playing id 3 with ids 4 and 5 queued; source 0 sends id 1 -> snd_abort 2 cycles later, queue flushed, snd_start with snd_id=1; ids 4 and 5 are never issued.
- Contention: same cycle, source 0 id 5, source 1 id 2, source 2 id 4 -> id 2 accepted, drop_cnt=2.
- Watchdog: snd_start then no snd_done for 90 startOfFrame pulses -> snd_abort pulse, state IDLE, the next queued id starts 2 cycles later.
- Done/priority race and reset: snd_done in the same cycle as a priority id -> no snd_abort, priority id issues. Asserting resetN low mid-PLAYING -> all outputs 0 and queue_count=0.
